// File: rtl/int_to_int_stream_if.sv
// Stream bundle for int_to_int_stream: input beat with micro-instruction,
// output beat with per-lane saturation flags and error flag.
interface int_to_int_stream_if #(
  parameter int LANES = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [32*LANES-1:0] in_data;
  logic [10:0]         in_cru;
  logic                out_valid;
  logic                out_ready;
  logic [32*LANES-1:0] out_data;
  logic [LANES-1:0]    out_sat;
  logic                out_err;

  modport master (
    output in_valid, in_data, in_cru, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_err
  );

  modport slave (
    input  in_valid, in_data, in_cru, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_err
  );
endinterface

// File: rtl/int_to_int_stream.sv
// Pipelined LANES x 32-bit integer format converter (8/16/32-bit, signed or
// unsigned, saturating). S1 decodes the micro-instruction, selects source
// fields and extends them to 33 bits; S2 clamps, packs and raises flags.
// A running saturated-lane counter sticks at all-ones.
module int_to_int_stream #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  int_to_int_stream_if.slave bus,
  input  logic               sat_clr,
  output logic [CNT_W-1:0]   sat_cnt
);
  localparam int         PC_W    = $clog2(LANES + 1);
  localparam logic [1:0] PREC_8  = 2'b00;
  localparam logic [1:0] PREC_16 = 2'b01;
  localparam logic [1:0] PREC_32 = 2'b10;

  // Raw field of a word for a given precision/position, zero-padded.
  function automatic logic [31:0] field_get(input logic [31:0] w, input logic [1:0] prec,
                                            input logic [1:0] pos);
    logic [31:0] r;
    case (prec)
      PREC_8: begin
        case (pos)
          2'd0:    r = {24'h0, w[7:0]};
          2'd1:    r = {24'h0, w[15:8]};
          2'd2:    r = {24'h0, w[23:16]};
          2'd3:    r = {24'h0, w[31:24]};
          default: r = 32'h0;
        endcase
      end
      PREC_16: r = pos[0] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
      PREC_32: r = w;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Sign- or zero-extend a raw field to the 33-bit internal value.
  function automatic logic [32:0] extend(input logic [31:0] raw, input logic [1:0] prec,
                                         input logic sgn);
    logic [32:0] r;
    case (prec)
      PREC_8:  r = {{25{sgn & raw[7]}}, raw[7:0]};
      PREC_16: r = {{17{sgn & raw[15]}}, raw[15:0]};
      PREC_32: r = {sgn & raw[31], raw};
      default: r = 33'h0;
    endcase
    return r;
  endfunction

  // Clamp to the destination range; returns {saturated, value[31:0]}.
  function automatic logic [32:0] clamp(input logic signed [32:0] v, input logic [1:0] prec,
                                        input logic sgn);
    logic signed [32:0] lo;
    logic signed [32:0] hi;
    logic [32:0]        r;
    case ({prec, sgn})
      3'b000:  begin lo = 33'sd0;           hi = 33'sd255;        end
      3'b001:  begin lo = -33'sd128;        hi = 33'sd127;        end
      3'b010:  begin lo = 33'sd0;           hi = 33'sd65535;      end
      3'b011:  begin lo = -33'sd32768;      hi = 33'sd32767;      end
      3'b100:  begin lo = 33'sd0;           hi = 33'sd4294967295; end
      3'b101:  begin lo = -33'sd2147483648; hi = 33'sd2147483647; end
      default: begin lo = 33'sd0;           hi = 33'sd0;          end
    endcase
    if (v < lo) begin
      r = {1'b1, lo[31:0]};
    end else if (v > hi) begin
      r = {1'b1, hi[31:0]};
    end else begin
      r = {1'b0, v[31:0]};
    end
    return r;
  endfunction

  // Number of set flags in a beat.
  function automatic logic [PC_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [PC_W-1:0] c;
    c = {PC_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  // Micro-instruction decode
  logic       instr_vld_s, src_signed_s, dst_signed_s, illegal_s, same_s;
  logic [1:0] src_prec_s, dst_prec_s, src_pos_s, dst_pos_s;

  assign instr_vld_s  = bus.in_cru[10];
  assign src_prec_s   = bus.in_cru[9:8];
  assign dst_prec_s   = bus.in_cru[7:6];
  assign src_signed_s = bus.in_cru[5];
  assign dst_signed_s = bus.in_cru[4];
  assign src_pos_s    = bus.in_cru[3:2];
  assign dst_pos_s    = bus.in_cru[1:0];
  assign illegal_s    = (src_prec_s == 2'b11) || (dst_prec_s == 2'b11);
  assign same_s       = (src_prec_s == dst_prec_s);

  // Pipeline state
  logic                s1_valid_r, s1_same_r, s1_dst_signed_r, s1_zero_r, s1_err_r;
  logic [1:0]          s1_dst_prec_r, s1_dst_pos_r;
  logic [32:0]         s1_elem_r [LANES][4];
  logic                out_valid_r, out_err_r;
  logic [32*LANES-1:0] out_data_r;
  logic [LANES-1:0]    out_sat_r;
  logic [CNT_W-1:0]    sat_cnt_r;

  // Handshake chain: a stage may load when it is empty or its consumer takes the beat.
  logic s2_ready_s, in_hs_s, out_hs_s;
  assign s2_ready_s   = !out_valid_r || bus.out_ready;
  assign bus.in_ready = !s1_valid_r || s2_ready_s;
  assign in_hs_s      = bus.in_valid && bus.in_ready;
  assign out_hs_s     = out_valid_r && bus.out_ready;

  // In same-width mode element k of a word comes from field k; mixed mode uses src_pos in slot 0.
  logic [32:0] ext_s [LANES][4];

  // Select source element(s) of each lane and extend to the internal width
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < 4; k++) begin
        ext_s[l][k] = extend(field_get(bus.in_data[32*(LANES-l)-1 -: 32], src_prec_s,
                                       same_s ? 2'(k) : src_pos_s),
                             src_prec_s, src_signed_s);
      end
    end
  end

  // Stage 1: capture decoded instruction and extended elements on input handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r      <= 1'b0;
      s1_same_r       <= 1'b0;
      s1_dst_signed_r <= 1'b0;
      s1_zero_r       <= 1'b0;
      s1_err_r        <= 1'b0;
      s1_dst_prec_r   <= 2'b00;
      s1_dst_pos_r    <= 2'b00;
      for (int l = 0; l < LANES; l++) begin
        for (int k = 0; k < 4; k++) begin
          s1_elem_r[l][k] <= 33'h0;
        end
      end
    end else begin
      if (bus.in_ready) begin
        s1_valid_r <= bus.in_valid;
      end
      if (in_hs_s) begin
        s1_same_r       <= same_s;
        s1_dst_signed_r <= dst_signed_s;
        s1_zero_r       <= !instr_vld_s || illegal_s;
        s1_err_r        <= instr_vld_s && illegal_s;
        s1_dst_prec_r   <= dst_prec_s;
        s1_dst_pos_r    <= dst_pos_s;
        s1_elem_r       <= ext_s;
      end
    end
  end

  logic [32:0]         clamp_s     [LANES][4];
  logic [31:0]         lane_word_s [LANES];
  logic                lane_sat_s  [LANES];
  logic [32*LANES-1:0] s2_data_s;
  logic [LANES-1:0]    s2_sat_s;

  // Clamp every element to the destination range and pack lane words and flags
  always_comb begin
    s2_data_s = {(32*LANES){1'b0}};
    s2_sat_s  = {LANES{1'b0}};
    for (int l = 0; l < LANES; l++) begin
      lane_word_s[l] = 32'h0;
      lane_sat_s[l]  = 1'b0;
      for (int k = 0; k < 4; k++) begin
        clamp_s[l][k] = clamp(s1_elem_r[l][k], s1_dst_prec_r, s1_dst_signed_r);
      end
      if (s1_zero_r) begin
        lane_word_s[l] = 32'h0;
        lane_sat_s[l]  = 1'b0;
      end else if (s1_same_r) begin
        case (s1_dst_prec_r)
          PREC_8: begin
            for (int k = 0; k < 4; k++) begin
              lane_word_s[l][8*k +: 8] = clamp_s[l][k][7:0];
              lane_sat_s[l]            = lane_sat_s[l] | clamp_s[l][k][32];
            end
          end
          PREC_16: begin
            for (int k = 0; k < 2; k++) begin
              lane_word_s[l][16*k +: 16] = clamp_s[l][k][15:0];
              lane_sat_s[l]              = lane_sat_s[l] | clamp_s[l][k][32];
            end
          end
          PREC_32: begin
            lane_word_s[l] = clamp_s[l][0][31:0];
            lane_sat_s[l]  = clamp_s[l][0][32];
          end
          default: begin
            lane_word_s[l] = 32'h0;
            lane_sat_s[l]  = 1'b0;
          end
        endcase
      end else begin
        lane_sat_s[l] = clamp_s[l][0][32];
        case (s1_dst_prec_r)
          PREC_8:  lane_word_s[l][{s1_dst_pos_r, 3'b000} +: 8] = clamp_s[l][0][7:0];
          PREC_16: lane_word_s[l][{s1_dst_pos_r[0], 4'b0000} +: 16] = clamp_s[l][0][15:0];
          PREC_32: lane_word_s[l] = clamp_s[l][0][31:0];
          default: lane_word_s[l] = 32'h0;
        endcase
      end
      s2_data_s[32*(LANES-l)-1 -: 32] = lane_word_s[l];
      s2_sat_s[LANES-1-l]             = lane_sat_s[l];
    end
  end

  // Stage 2: register result beat; hold everything while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {(32*LANES){1'b0}};
      out_sat_r   <= {LANES{1'b0}};
      out_err_r   <= 1'b0;
    end else if (s2_ready_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_data_r <= s2_data_s;
        out_sat_r  <= s2_sat_s;
        out_err_r  <= s1_err_r;
      end
    end
  end

  logic [PC_W-1:0] pc_s;
  logic [CNT_W:0]  sum_s;
  assign pc_s  = popcount(out_sat_r);
  assign sum_s = {1'b0, sat_cnt_r} + (CNT_W+1)'(pc_s);

  // Saturation event counter: accumulate flags per delivered beat, stick at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt_r <= {CNT_W{1'b0}};
    end else if (sat_clr) begin
      sat_cnt_r <= out_hs_s ? CNT_W'(pc_s) : {CNT_W{1'b0}};
    end else if (out_hs_s) begin
      sat_cnt_r <= sum_s[CNT_W] ? {CNT_W{1'b1}} : sum_s[CNT_W-1:0];
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_sat   = out_sat_r;
  assign bus.out_err   = out_err_r;
  assign sat_cnt       = sat_cnt_r;
endmodule

// File: doc/int_to_int_stream.md
# int_to_int_stream

Parametrised, pipelined successor to the fixed 4-lane integer-to-integer converter in the SMC datapath. Converts LANES × 32-bit words between 8/16/32-bit, signed/unsigned integer formats with saturation, behind a valid/ready stream interface. Reports per-lane saturation flags and keeps a running saturation counter. Sits between the vector register read path and the destination register write-back.

## Interface
- LANES, 4, number of 32-bit lanes (1..16)
- CNT_W, 16, width of saturation event counter
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept input beat
- in_data  in  32*LANES  source words; lane i at [32*(LANES-i)-1 -: 32] (lane 0 = MSBs)
- in_cru  in  11  micro-instruction, captured with in_data: [10] instr_vld, [9:8] src_prec, [7:6] dst_prec, [5] src_signed, [4] dst_signed, [3:2] src_pos, [1:0] dst_pos; prec 00=8b, 01=16b, 10=32b, 11=illegal
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  32*LANES  converted words, same lane order
- out_sat  out  LANES  per-lane: any element of that lane clamped
- out_err  out  1  beat carried illegal precision code
- sat_clr  in  1  synchronous clear of sat_cnt
- sat_cnt  out  CNT_W  saturated-lane count, sticks at all-ones

## Operation
- Same-width mode (src_prec == dst_prec): every element in each word converted independently (4×8b, 2×16b, 1×32b); src_pos/dst_pos ignored.
- Mixed-width mode: one element per lane. Source element = field src_pos of the word (8b: pos 0..3 = bits [7:0]..[31:24]; 16b: pos 0/1 = [15:0]/[31:16]; pos bit 1 ignored for 16b; both ignored for 32b). Result written to field dst_pos with same mapping; all other bits of the word 0.
- Source extension: signed → sign-extend, unsigned → zero-extend to 33-bit internal value.
- Clamp to destination range: s8 [-128,127], u8 [0,255], s16 [-32768,32767], u16 [0,65535], s32 [-2^31,2^31-1], u32 [0,2^32-1]. Clamp occurs → lane's out_sat = 1.
- instr_vld = 0: beat still flows, out_data = 0, out_sat = 0, out_err = 0.
- src_prec or dst_prec = 11 (with instr_vld = 1): out_data = 0, out_sat = 0, out_err = 1.
- sat_cnt: on each output handshake (out_valid & out_ready) adds popcount(out_sat), saturating at 2^CNT_W-1. sat_clr without handshake → 0; sat_clr with handshake same cycle → loads popcount of that beat.

## Timing
- Two register stages: S1 (decode, field select, extension), S2 (clamp, pack, flags). Latency 2 cycles from input handshake to out_valid with out_ready held high.
- Throughput 1 beat/cycle when out_ready = 1.
- Stall: s2_ready = !out_valid | out_ready; in_ready = !s1_valid | s2_ready (combinational chain, no bubbles). Stalled stage holds data, cru, flags stable.
- out_data/out_sat/out_err/out_valid must not change while out_valid & !out_ready.
- in_data/in_cru sampled only on in_valid & in_ready.
- Reset: both stage valids 0, out_valid 0, out_data 0, out_sat 0, out_err 0, sat_cnt 0; in_ready = 1 in first cycle after reset. Reset mid-stream drops in-flight beats; nothing emitted afterwards from them.
- No combinational path from in_valid/in_data to out_*.

## Test plan
- LANES=4, s32→s16 low (cru 11'b1_10_01_1_1_00_00), data {00007FFF,00008000,FFFF8000,FFFF7FFF}, out_ready=1 → 2 cycles later {00007FFF,00007FFF,00008000,00008000}, out_sat=4'b0101, sat_cnt=2.
- u8→s8 packed (1_00_00_0_1_xx_xx), word 0x80FF7F01 → 0x7F7F7F01, lane flag 1; s8→u16 src_pos=3 dst_pos=1, word 0xFE000000 → 0x00000000 sat, word 0x7F000000 → 0x007F0000.
- Back-to-back 8 beats, out_ready toggled 1,0,0,1,… → all 8 beats emitted in order, none lost or duplicated, out_data stable during stall, in_ready low only when both stages full.
- instr_vld=0 beat between two valid beats → middle output all-zero, flags 0; src_prec=11 beat → out_data 0, out_err 1.
- sat_cnt: preload to 0xFFFE via saturating beats (CNT_W=16 or reduced CNT_W=4 with 15+ events) → sticks at all-ones; sat_clr coincident with 3-flag beat → sat_cnt=3.
- rst asserted with both stages full and out_ready=0 → next cycle out_valid=0, out_data=0, sat_cnt=0, in_ready=1.
